cordic_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the CORDIC sine/cosine generator. It drives the generator's freq word through a programmed start/stop/step schedule. After each frequency change it waits out the angle-generator and CORDIC pipeline, then asserts a sample-enable window for a programmed dwell. It sits between the host/config registers and the generator's freq input; downstream capture logic qualifies SIN/COS samples with sample_en.

---
 rtl/cordic_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_ctrl.sv
// Frequency-sweep sequencer for the CORDIC sin/cos generator: settle, dwell, step.
// Optional `define SWEEP_TRIANGLE_EN makes looped sweeps bounce between start and stop.
module cordic_sweep_ctrl #(
  parameter int FREQ_WIDTH    = 12,
  parameter int DWELL_WIDTH   = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int IDX_WIDTH     = 12
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FREQ_WIDTH-1:0]  cfg_start_freq,
  input  logic [FREQ_WIDTH-1:0]  cfg_stop_freq,
  input  logic [FREQ_WIDTH-1:0]  cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  output logic [FREQ_WIDTH-1:0]  freq,
  output logic                   busy,
  output logic                   sample_en,
  output logic [IDX_WIDTH-1:0]   step_idx,
  output logic                   done
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW  = (SCW > DWELL_WIDTH) ? SCW : DWELL_WIDTH;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DWELL, S_STEP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   busy_q, busy_d;
  logic                   sample_en_q, sample_en_d;
  logic                   done_q, done_d;
  logic [FREQ_WIDTH-1:0]  start_f_q, start_f_d;
  logic [FREQ_WIDTH-1:0]  stop_f_q, stop_f_d;
  logic [FREQ_WIDTH-1:0]  step_f_q, step_f_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   loop_q, loop_d;
`ifdef SWEEP_TRIANGLE_EN
  logic                   dir_q, dir_d;   // 1 = sweeping down
`endif

  logic [FREQ_WIDTH:0] up_sum, dn_diff;
  logic                up_ok, dn_ok;
  logic [CW-1:0]       dwell_load;

  // One extra bit catches carry-out (up) and borrow (down) so freq never wraps.
  assign up_sum  = {1'b0, freq_q} + {1'b0, step_f_q};
  assign dn_diff = {1'b0, freq_q} - {1'b0, step_f_q};
  assign up_ok   = (step_f_q != '0) && !up_sum[FREQ_WIDTH] && (up_sum <= {1'b0, stop_f_q});
  assign dn_ok   = (step_f_q != '0) && !dn_diff[FREQ_WIDTH] &&
                   (dn_diff[FREQ_WIDTH-1:0] >= start_f_q);
  assign dwell_load = (dwell_q == '0) ? '0 : CW'(dwell_q - DWELL_WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    idx_d     = idx_q;
    start_f_d = start_f_q;
    stop_f_d  = stop_f_q;
    step_f_d  = step_f_q;
    dwell_d   = dwell_q;
    loop_d    = loop_q;
`ifdef SWEEP_TRIANGLE_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          start_f_d = cfg_start_freq;
          stop_f_d  = cfg_stop_freq;
          step_f_d  = cfg_step;
          dwell_d   = cfg_dwell;
          loop_d    = cfg_loop;
          freq_d    = cfg_start_freq;
          idx_d     = '0;
          cnt_d     = SETTLE_LOAD;
          state_d   = S_SETTLE;
`ifdef SWEEP_TRIANGLE_EN
          dir_d     = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = dwell_load;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == '0) state_d = S_STEP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_STEP: begin
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
`ifdef SWEEP_TRIANGLE_EN
        if (dir_q ? dn_ok : up_ok) begin
          freq_d = dir_q ? dn_diff[FREQ_WIDTH-1:0] : up_sum[FREQ_WIDTH-1:0];
          idx_d  = idx_q + IDX_WIDTH'(1);
        end else if (loop_q && (dir_q ? up_ok : dn_ok)) begin
          // Reverse straight to the next point so the endpoint is not dwelt twice.
          freq_d = dir_q ? up_sum[FREQ_WIDTH-1:0] : dn_diff[FREQ_WIDTH-1:0];
          idx_d  = idx_q + IDX_WIDTH'(1);
          dir_d  = ~dir_q;
        end else if (loop_q) begin
          freq_d = start_f_q;
          idx_d  = '0;
          dir_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
`else
        if (up_ok) begin
          freq_d = up_sum[FREQ_WIDTH-1:0];
          idx_d  = idx_q + IDX_WIDTH'(1);
        end else if (loop_q) begin
          freq_d = start_f_q;
          idx_d  = '0;
        end else begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      freq_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
`ifdef SWEEP_TRIANGLE_EN
      dir_d   = 1'b0;
`endif
    end

    sample_en_d = (state_d == S_DWELL);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      freq_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      sample_en_q <= 1'b0;
      done_q      <= 1'b0;
      start_f_q   <= '0;
      stop_f_q    <= '0;
      step_f_q    <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freq_q      <= freq_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      sample_en_q <= sample_en_d;
      done_q      <= done_d;
      start_f_q   <= start_f_d;
      stop_f_q    <= stop_f_d;
      step_f_q    <= step_f_d;
      dwell_q     <= dwell_d;
      loop_q      <= loop_d;
`ifdef SWEEP_TRIANGLE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign freq      = freq_q;
  assign busy      = busy_q;
  assign sample_en = sample_en_q;
  assign step_idx  = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Directed bench for cordic_sweep_ctrl: records each sample_en window and compares
// frequency, index, length and spacing against hand-computed schedules.
module tb_cordic_sweep_ctrl;
  localparam int FW = 12;
  localparam int DW = 16;
  localparam int SC = 16;
  localparam int IW = 12;

  logic          clock;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [FW-1:0] cfg_start_freq;
  logic [FW-1:0] cfg_stop_freq;
  logic [FW-1:0] cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic          cfg_loop;
  logic [FW-1:0] freq;
  logic          busy;
  logic          sample_en;
  logic [IW-1:0] step_idx;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  int pt_freq[16];
  int pt_idx[16];
  int pt_len[16];
  int pt_at[16];
  int n_pts;
  int n_done;
  int exp_f[8];
  int exp_i[8];

  cordic_sweep_ctrl #(
    .FREQ_WIDTH(FW), .DWELL_WIDTH(DW), .SETTLE_CYCLES(SC), .IDX_WIDTH(IW)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .freq(freq), .busy(busy), .sample_en(sample_en),
    .step_idx(step_idx), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_sweep(input int sf, input int sp, input int st, input int dw, input int lp);
    @(negedge clock);
    cfg_start_freq = FW'(sf);
    cfg_stop_freq  = FW'(sp);
    cfg_step       = FW'(st);
    cfg_dwell      = DW'(dw);
    cfg_loop       = lp[0];
    start          = 1'b1;
    @(negedge clock);
    start          = 1'b0;
  endtask

  // Called at a negedge; k counts cycles since the edge that accepted start.
  task automatic collect(input int max_pts, input int budget, input int k_init);
    int  k;
    bit  prev;
    bit  stop_now;
    k = k_init; prev = 1'b0; stop_now = 1'b0; n_pts = 0; n_done = 0;
    while (!stop_now) begin
      if (sample_en && !prev) begin
        if (n_pts < 16) begin
          pt_freq[n_pts] = int'(freq);
          pt_idx[n_pts]  = int'(step_idx);
          pt_len[n_pts]  = 1;
          pt_at[n_pts]   = k;
        end
        n_pts++;
      end else if (sample_en && n_pts > 0 && n_pts <= 16) begin
        pt_len[n_pts-1]++;
      end
      if (done) begin
        n_done++;
        stop_now = 1'b1;
      end
      if (n_pts == max_pts && prev && !sample_en) stop_now = 1'b1;
      if (!stop_now && k >= budget) begin
        check("collect_timeout_points", n_pts, max_pts);
        stop_now = 1'b1;
      end
      prev = sample_en;
      if (!stop_now) begin
        @(negedge clock);
        k++;
      end
    end
    $display("collect: %0d points, %0d done pulses, stopped at cycle %0d", n_pts, n_done, k);
  endtask

  task automatic check_points(input string name, input int n, input int dwell);
    int len;
    len = (dwell == 0) ? 1 : dwell;
    check({name, "_npts"}, n_pts, n);
    for (int i = 0; i < n && i < 16; i++) begin
      $display("%s point %0d: freq=%0d idx=%0d len=%0d at=%0d", name, i, pt_freq[i], pt_idx[i], pt_len[i], pt_at[i]);
      check($sformatf("%s_freq%0d", name, i), pt_freq[i], exp_f[i]);
      check($sformatf("%s_idx%0d", name, i), pt_idx[i], exp_i[i]);
      check($sformatf("%s_len%0d", name, i), pt_len[i], len);
      if (i > 0) check($sformatf("%s_gap%0d", name, i), pt_at[i] - pt_at[i-1], SC + len + 1);
    end
  endtask

  initial begin
    int w;
    int seen_busy;
    int seen_en;
    int seen_done;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_freq = '0; cfg_stop_freq = '0; cfg_step = '0; cfg_dwell = '0; cfg_loop = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_freq", freq, 0);
    check("rst_busy", busy, 0);
    check("rst_sample_en", sample_en, 0);
    check("rst_step_idx", step_idx, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);

    // Basic sweep 100..130 step 10, dwell 4
    start_sweep(100, 130, 10, 4, 0);
    check("t2_busy_after_start", busy, 1);
    check("t2_freq_after_start", freq, 100);
    collect(16, 400, 1);
    exp_f = '{100, 110, 120, 130, 0, 0, 0, 0};
    exp_i = '{0, 1, 2, 3, 0, 0, 0, 0};
    check_points("t2", 4, 4);
    check("t2_first_latency", pt_at[0], 1 + SC);
    check("t2_done_count", n_done, 1);
    check("t2_busy_in_done", busy, 1);
    @(negedge clock);
    check("t2_busy_after_done", busy, 0);
    check("t2_done_one_cycle", done, 0);
    check("t2_freq_held", freq, 130);

    // Near the top of the range: 4090+10 carries out of 12 bits
    start_sweep(4090, 4095, 10, 2, 0);
    collect(16, 200, 1);
    exp_f = '{4090, 0, 0, 0, 0, 0, 0, 0};
    exp_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_points("t3_ovf", 1, 2);
    check("t3_ovf_done", n_done, 1);
    @(negedge clock);
    check("t3_ovf_freq_held", freq, 4090);

    start_sweep(50, 100, 0, 3, 0);
    collect(16, 200, 1);
    exp_f = '{50, 0, 0, 0, 0, 0, 0, 0};
    check_points("t3_step0", 1, 3);
    check("t3_step0_done", n_done, 1);

    start_sweep(200, 100, 5, 2, 0);
    collect(16, 200, 1);
    exp_f = '{200, 0, 0, 0, 0, 0, 0, 0};
    check_points("t3_start_gt_stop", 1, 2);
    check("t3_sgs_done", n_done, 1);
    @(negedge clock);

    // Loop, then abort during SETTLE
    start_sweep(0, 20, 10, 3, 1);
    collect(5, 400, 1);
`ifdef SWEEP_TRIANGLE_EN
    exp_f = '{0, 10, 20, 10, 0, 0, 0, 0};
    exp_i = '{0, 1, 2, 3, 4, 0, 0, 0};
`else
    exp_f = '{0, 10, 20, 0, 10, 0, 0, 0};
    exp_i = '{0, 1, 2, 0, 1, 0, 0, 0};
`endif
    check_points("t4", 5, 3);
    check("t4_no_done", n_done, 0);
    repeat (3) @(negedge clock);
    check("t4_in_settle_busy", busy, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_freq", freq, 0);
    check("t4_abort_sample_en", sample_en, 0);
    seen_busy = 0; seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      seen_done += int'(done);
      seen_busy += int'(busy);
      @(negedge clock);
    end
    check("t4_abort_no_done", seen_done, 0);
    check("t4_abort_stays_idle", seen_busy, 0);

    // cfg changes and start pulses while busy are ignored
    start_sweep(100, 130, 10, 2, 0);
    repeat (2) @(negedge clock);
    cfg_start_freq = 12'd500; cfg_stop_freq = 12'd4000; cfg_step = 12'd1;
    cfg_dwell = 16'd9; cfg_loop = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    collect(16, 400, 4);
    exp_f = '{100, 110, 120, 130, 0, 0, 0, 0};
    exp_i = '{0, 1, 2, 3, 0, 0, 0, 0};
    check_points("t5_cfg", 4, 2);
    check("t5_cfg_done", n_done, 1);

    start_sweep(0, 20, 10, 0, 0);
    collect(16, 300, 1);
    exp_f = '{0, 10, 20, 0, 0, 0, 0, 0};
    exp_i = '{0, 1, 2, 0, 0, 0, 0, 0};
    check_points("t5_dwell0", 3, 0);
    check("t5_dwell0_done", n_done, 1);
    @(negedge clock);

    cfg_start_freq = 12'd5; cfg_stop_freq = 12'd50; cfg_step = 12'd5;
    cfg_dwell = 16'd2; cfg_loop = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    check("t5_start_abort_busy", busy, 0);
    seen_busy = 0; seen_en = 0;
    for (int i = 0; i < 20; i++) begin
      seen_busy += int'(busy);
      seen_en   += int'(sample_en);
      @(negedge clock);
    end
    check("t5_start_abort_no_busy", seen_busy, 0);
    check("t5_start_abort_no_sample", seen_en, 0);

    // Looping 0..30: triangle build bounces, default build restarts
    start_sweep(0, 30, 10, 4, 1);
    collect(8, 600, 1);
`ifdef SWEEP_TRIANGLE_EN
    exp_f = '{0, 10, 20, 30, 20, 10, 0, 10};
    exp_i = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
    exp_f = '{0, 10, 20, 30, 0, 10, 20, 30};
    exp_i = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    check_points("t6", 8, 4);
    check("t6_no_done", n_done, 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);

    // Reset in the middle of a dwell window
    start_sweep(100, 130, 10, 4, 0);
    w = 0;
    while (!sample_en && w < 40) begin
      @(negedge clock);
      w++;
    end
    check("t1_reached_dwell", sample_en, 1);
    #2 resetn = 1'b0;
    #1;
    check("t1_async_freq", freq, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_sample_en", sample_en, 0);
    check("t1_async_step_idx", step_idx, 0);
    check("t1_async_done", done, 0);
    @(negedge clock);
    resetn = 1'b1;
    seen_busy = 0; seen_en = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      seen_busy += int'(busy);
      seen_en   += int'(sample_en);
    end
    check("t1_no_resume_busy", seen_busy, 0);
    check("t1_no_resume_sample", seen_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
